// File: rtl/test_unit.sv
// test_unit: registered two-input logic cell.
// Each raw input is synchronised, debounced and stripped of X/Z, then the two
// clean levels are combined by a parameter-selected Boolean function into z.

// Per-input conditioning path: two-flop synchroniser followed by a
// consecutive-sample debounce filter.
module TestUnitDebounce #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CntW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  logic            s1_q;
  logic            s2_q;
  logic            f_q;
  logic            f_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            sampleKnown;

  // Two-flop synchroniser bringing the asynchronous raw level into clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s2_next(s1_q);
    end
  end

  // Pass-through helper; keeps the synchroniser stages visibly separate.
  function automatic logic s2_next(input logic v);
    return v;
  endfunction

  // A sample only counts toward a transition when it is a clean 0 or 1.
  always_comb begin
    sampleKnown = (s2_q === 1'b0) || (s2_q === 1'b1);
  end

  // Debounce decision: accept a new level only after enough consecutive
  // differing samples; any matching or unknown sample restarts the count.
  always_comb begin
    f_d   = f_q;
    cnt_d = '0;
    if (sampleKnown && (s2_q !== f_q)) begin
      if (cnt_q == CntMax) begin
        f_d   = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign filt_o = f_q;

endmodule

// Top level: two independent conditioning paths feeding a registered
// Boolean combine stage.
module test_unit #(
  parameter int FUNC          = 0,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic y,
  output logic z
);

  logic xf;
  logic yf;
  logic z_q;
  logic z_d;

  // Selected combine function; unlisted codes fall back to AND.
  function automatic logic combine(input logic a, input logic b);
    logic r;
    case (FUNC)
      1:       r = a | b;
      2:       r = a ^ b;
      3:       r = ~(a ^ b);
      default: r = a & b;
    endcase
    return r;
  endfunction

  TestUnitDebounce #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_xPath (
    .clk   (clk),
    .rst   (rst),
    .raw_i (x),
    .filt_o(xf)
  );

  TestUnitDebounce #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_yPath (
    .clk   (clk),
    .rst   (rst),
    .raw_i (y),
    .filt_o(yf)
  );

  // Combine the two filtered levels; both are always clean so z_d is too.
  always_comb begin
    z_d = combine(xf, yf);
  end

  // Output register; cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q <= 1'b0;
    end else begin
      z_q <= z_d;
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_test_unit.sv
// tb_test_unit: directed self-checking bench for test_unit.
// Several instances share the same inputs: default AND/4, XNOR/4, and a
// STABLE_CYCLES=1 instance for each of the four combine functions.
module tb_test_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       x   = 1'b0;
  logic       y   = 1'b0;
  logic       zDef;
  logic       zXnor;
  logic [3:0] zSweep;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  test_unit #(.FUNC(0), .STABLE_CYCLES(4)) dutDef (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(zDef)
  );
  test_unit #(.FUNC(3), .STABLE_CYCLES(4)) dutXnor (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(zXnor)
  );
  test_unit #(.FUNC(0), .STABLE_CYCLES(1)) dutAnd1 (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(zSweep[0])
  );
  test_unit #(.FUNC(1), .STABLE_CYCLES(1)) dutOr1 (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(zSweep[1])
  );
  test_unit #(.FUNC(2), .STABLE_CYCLES(1)) dutXor1 (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(zSweep[2])
  );
  test_unit #(.FUNC(3), .STABLE_CYCLES(1)) dutXnor1 (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(zSweep[3])
  );

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive both raw inputs.
  task automatic applyStimulus(input logic xv, input logic yv);
    x = xv;
    y = yv;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  logic [1:0] sweepIn  [4];
  logic [3:0] sweepExp [4];

  initial begin
    // {XNOR, XOR, OR, AND} for each (x,y), starting from (0,0) -> 1000
    sweepIn[0] = 2'b01; sweepExp[0] = 4'b0110;
    sweepIn[1] = 2'b10; sweepExp[1] = 4'b0110;
    sweepIn[2] = 2'b11; sweepExp[2] = 4'b1011;
    sweepIn[3] = 2'b00; sweepExp[3] = 4'b1000;

    // Reset behaviour
    applyStimulus(1'b0, 1'b0);
    #1 rst = 1'b1;
    waitCycles(2);
    checkOutput("resetDefZ", {3'b0, zDef}, 4'b0);
    checkOutput("resetXnorZ", {3'b0, zXnor}, 4'b0);
    rst = 1'b0;
    waitCycles(1);
    checkOutput("releaseDefZ", {3'b0, zDef}, 4'b0);
    checkOutput("releaseXnorZ", {3'b0, zXnor}, 4'b1);
    checkOutput("releaseSweep", zSweep, 4'b1000);

    // Clean simultaneous transition: z changes once at edge k+6
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      waitCycles(1);
      checkOutput("cleanDefLow", {3'b0, zDef}, 4'b0);
      checkOutput("cleanXnorHeld", {3'b0, zXnor}, 4'b1);
    end
    waitCycles(1);
    checkOutput("cleanDefHigh", {3'b0, zDef}, 4'b1);
    checkOutput("cleanXnorHeld", {3'b0, zXnor}, 4'b1);

    applyStimulus(1'b0, 1'b0);
    waitCycles(10);
    checkOutput("backToZero", {3'b0, zDef}, 4'b0);

    // Unknown input on y never reaches the filter or z
    x = 1'b1;
    y = 1'bx;
    for (int i = 0; i < 20; i++) begin
      waitCycles(1);
      checkOutput("unknownZ", {3'b0, zDef}, 4'b0);
    end
    checkOutput("unknownXf", {3'b0, dutDef.xf}, 4'b1);
    checkOutput("unknownYf", {3'b0, dutDef.yf}, 4'b0);
    y = 1'b1;
    for (int i = 0; i < 6; i++) begin
      waitCycles(1);
      checkOutput("yCleanLow", {3'b0, zDef}, 4'b0);
    end
    waitCycles(1);
    checkOutput("yCleanHigh", {3'b0, zDef}, 4'b1);

    // Glitch rejection: a 3-sample pulse is discarded
    applyStimulus(1'b0, 1'b0);
    waitCycles(10);
    checkOutput("preGlitchZ", {3'b0, zDef}, 4'b0);
    applyStimulus(1'b1, 1'b1);
    waitCycles(3);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      waitCycles(1);
      checkOutput("shortPulseZ", {3'b0, zDef}, 4'b0);
    end

    // A 5-sample pulse is long enough to pass
    applyStimulus(1'b1, 1'b1);
    waitCycles(5);
    applyStimulus(1'b0, 1'b0);
    waitCycles(1);
    checkOutput("longPulseEarly", {3'b0, zDef}, 4'b0);
    waitCycles(1);
    checkOutput("longPulseRise", {3'b0, zDef}, 4'b1);
    waitCycles(12);
    checkOutput("longPulseFall", {3'b0, zDef}, 4'b0);

    // Function sweep at STABLE_CYCLES=1: new value lands at edge k+3
    checkOutput("sweepStart", zSweep, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] prevExp;
      prevExp = (i == 0) ? 4'b1000 : sweepExp[i-1];
      applyStimulus(sweepIn[i][1], sweepIn[i][0]);
      waitCycles(3);
      checkOutput("sweepLatency", zSweep, prevExp);
      waitCycles(1);
      checkOutput("sweepTruth", zSweep, sweepExp[i]);
    end

    // Asynchronous reset between edges
    applyStimulus(1'b1, 1'b1);
    waitCycles(12);
    checkOutput("preAsyncZ", {3'b0, zDef}, 4'b1);
    #3 rst = 1'b1;
    #1;
    checkOutput("asyncDefZ", {3'b0, zDef}, 4'b0);
    checkOutput("asyncXnorZ", {3'b0, zXnor}, 4'b0);
    waitCycles(2);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      waitCycles(1);
      checkOutput("postResetLow", {3'b0, zDef}, 4'b0);
    end
    waitCycles(1);
    checkOutput("postResetHigh", {3'b0, zDef}, 4'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
